// File: rtl/wifi_tx_puncture_ctrl.sv
// Puncturing sequencer between the convolutional encoder and the interleaver.
// Optional: define WIFI_PUNCT_R23_EN to build rate 2/3; otherwise rate=10 is reserved.
module wifi_tx_puncture_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       rate,
  input  logic [LEN_W-1:0] num_out,
  input  logic             valid_in,
  input  logic             data_in,
  output logic             valid_out,
  output logic             data_out,
  output logic             finished,
  output logic             busy,
  output logic             rate_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] R12 = 2'b00;
  localparam logic [1:0] R34 = 2'b01;
`ifdef WIFI_PUNCT_R23_EN
  localparam logic [1:0] R23 = 2'b10;
`endif

  state_t           state;
  logic [1:0]       rate_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] out_cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic [2:0]       ptr;
  logic [2:0]       ptr_nxt;
  logic             en_q;
  logic             keep;
  logic             wrap;
  logic [1:0]       eff_rate;
  logic             reserved;

  // Reserved codes fall back to the 1/2 pattern and raise rate_err.
  always_comb begin
    eff_rate = R12;
    reserved = 1'b0;
    case (rate)
      2'b00: eff_rate = R12;
      2'b01: eff_rate = R34;
`ifdef WIFI_PUNCT_R23_EN
      2'b10: eff_rate = R23;
`endif
      default: reserved = 1'b1;
    endcase
  end

  always_comb begin
    keep = 1'b1;
    wrap = (ptr == 3'd1);
    case (rate_q)
      R34: begin
        keep = !(ptr == 3'd3 || ptr == 3'd4);
        wrap = (ptr == 3'd5);
      end
`ifdef WIFI_PUNCT_R23_EN
      R23: begin
        keep = (ptr != 3'd3);
        wrap = (ptr == 3'd3);
      end
`endif
      default: ;
    endcase
  end

  assign ptr_nxt = wrap ? 3'd0 : ptr + 3'd1;
  assign cnt_inc = out_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rate_q    <= R12;
      len_q     <= '0;
      out_cnt   <= '0;
      ptr       <= '0;
      en_q      <= 1'b1;  // an enable held high across reset is not a fresh edge
      valid_out <= 1'b0;
      data_out  <= 1'b0;
      finished  <= 1'b0;
      busy      <= 1'b0;
      rate_err  <= 1'b0;
    end else begin
      en_q      <= enable;
      valid_out <= 1'b0;
      data_out  <= 1'b0;
      finished  <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !en_q) begin
            rate_q   <= eff_rate;
            len_q    <= num_out;
            ptr      <= '0;
            out_cnt  <= '0;
            rate_err <= reserved;
            if (num_out == '0) begin
              state <= DONE;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (valid_in) begin
            ptr <= ptr_nxt;
            if (keep) begin
              valid_out <= 1'b1;
              data_out  <= data_in;
              out_cnt   <= cnt_inc;
            end
          end
          // Abort outranks completion; the bit captured above still emits.
          if (!enable) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ptr     <= '0;
            out_cnt <= '0;
          end else if (valid_in && keep && cnt_inc == len_q) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          finished <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wifi_tx_puncture_ctrl.sv
// Bench for wifi_tx_puncture_ctrl: directed frames plus randomized frames checked
// every cycle against a frame-level model of the puncturing rules.
module tb_wifi_tx_puncture_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  rate = 2'b00;
  logic [15:0] num_out = '0;
  logic        valid_in = 1'b0;
  logic        data_in = 1'b0;
  logic        valid_out, data_out, finished, busy, rate_err;

  int n_cmp = 0;
  int n_bad = 0;

  wifi_tx_puncture_ctrl #(.LEN_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rate(rate), .num_out(num_out),
    .valid_in(valid_in), .data_in(data_in), .valid_out(valid_out),
    .data_out(data_out), .finished(finished), .busy(busy), .rate_err(rate_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Keep/drop tables indexed by the count of coded bits seen in the frame.
  localparam bit M34 [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam bit M23 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  function automatic bit pat_keep(input int r, input int idx);
    case (r)
      34: return M34[idx % 6];
      23: return M23[idx % 4];
      default: return 1'b1;
    endcase
  endfunction

  function automatic int code_rate(input logic [1:0] r);
    case (r)
      2'b00: return 12;
      2'b01: return 34;
`ifdef WIFI_PUNCT_R23_EN
      2'b10: return 23;
`endif
      default: return 0;
    endcase
  endfunction

  // Frame-level model
  logic exp_vo = 0, exp_do = 0, exp_fin = 0, exp_busy = 0, exp_err = 0;
  bit   m_run = 0, m_done = 0, m_en_prev = 1;
  int   m_rate = 12, m_len = 0, m_nin = 0, m_nout = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_vo = 0; exp_do = 0; exp_fin = 0; exp_busy = 0; exp_err = 0;
      m_run = 0; m_done = 0; m_en_prev = 1;
    end else begin
      bit k;
      k = 0;
      exp_vo = 0; exp_do = 0; exp_fin = 0;
      if (m_done) begin
        exp_fin = 1;
        m_done = 0;
      end else if (m_run) begin
        if (valid_in) begin
          k = pat_keep(m_rate, m_nin);
          m_nin++;
          if (k) begin
            exp_vo = 1; exp_do = data_in; m_nout++;
          end
        end
        if (!enable) m_run = 0;
        else if (k && m_nout == m_len) begin
          m_run = 0; m_done = 1;
        end
      end else if (enable && !m_en_prev) begin
        m_rate  = code_rate(rate);
        exp_err = (m_rate == 0);
        if (m_rate == 0) m_rate = 12;
        m_len = int'(num_out); m_nin = 0; m_nout = 0;
        if (num_out == 0) m_done = 1;
        else m_run = 1;
      end
      exp_busy  = m_run;
      m_en_prev = enable;
    end
  end

  // Per-cycle compare and output capture
  bit cap[$];
  int fin_cnt = 0;

  always @(posedge clk) begin
    #1;
    chk("valid_out", valid_out, exp_vo);
    chk("finished", finished, exp_fin);
    chk("busy", busy, exp_busy);
    chk("rate_err", rate_err, exp_err);
    if (exp_vo) chk("data_out", data_out, exp_do);
    if (valid_out) cap.push_back(data_out);
    if (finished) fin_cnt++;
  end

  function automatic logic [31:0] packed_cap();
    logic [31:0] v = '0;
    for (int i = 0; i < cap.size() && i < 32; i++) v[i] = cap[i];
    return v;
  endfunction

  task automatic clr();
    cap.delete();
    fin_cnt = 0;
  endtask

  // Bits are sent bit 0 first; rate/num_out are scrambled mid-frame on purpose.
  task automatic run_frame(input logic [1:0] r, input int len, input logic [63:0] bits,
                           input int nbits, input int gap_pct, input int abort_at,
                           input int ncyc);
    int k = 0;
    @(negedge clk);
    enable = 1; rate = r; num_out = 16'(len); valid_in = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rate = 2'($urandom); num_out = 16'($urandom);
      if (c == abort_at) enable = 0;
      if (k < nbits && int'($urandom_range(99)) >= gap_pct) begin
        valid_in = 1; data_in = bits[k]; k++;
      end else begin
        valid_in = 0; data_in = 1'($urandom);
      end
    end
    @(negedge clk);
    valid_in = 0; enable = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_vo", valid_out, 1'b0);
    reset = 1;
    repeat (2) @(negedge clk);

    // 3/4, eight kept bits out of twelve
    clr();
    run_frame(2'b01, 8, 64'b110110101101, 12, 0, -1, 16);
    chk("r34_count", cap.size(), 8);
    chk("r34_bits", packed_cap(), 32'hED);
    chk("r34_fin", fin_cnt, 1);

    // 1/2 with gaps, extra inputs ignored
    clr();
    run_frame(2'b00, 5, 64'b1001110110, 10, 40, -1, 40);
    chk("r12_count", cap.size(), 5);
    chk("r12_bits", packed_cap(), 32'h16);
    chk("r12_fin", fin_cnt, 1);

    // rate 10: 2/3 when built, else reserved 1/2
    clr();
    run_frame(2'b10, 6, 64'b10001111, 8, 0, -1, 12);
    chk("r23_count", cap.size(), 6);
`ifdef WIFI_PUNCT_R23_EN
    chk("r23_bits", packed_cap(), 32'h07);
    chk("r23_err", rate_err, 1'b0);
`else
    chk("r23_bits", packed_cap(), 32'h0F);
    chk("r23_err", rate_err, 1'b1);
`endif

    // zero-length frame
    clr();
    run_frame(2'b00, 0, 64'hFF, 4, 0, -1, 6);
    chk("zero_count", cap.size(), 0);
    chk("zero_fin", fin_cnt, 1);

    // abort then restart at 1/2
    clr();
    run_frame(2'b01, 8, 64'b10111, 5, 0, 5, 8);
    chk("abort_fin", fin_cnt, 0);
    chk("abort_busy", busy, 1'b0);
    clr();
    run_frame(2'b00, 2, 64'b01, 2, 0, -1, 6);
    chk("restart_count", cap.size(), 2);
    chk("restart_bits", packed_cap(), 32'h1);

    // async reset mid-RUN
    @(negedge clk);
    enable = 1; rate = 2'b11; num_out = 16'd40;
    repeat (3) begin
      @(negedge clk); valid_in = 1; data_in = 1;
    end
    @(posedge clk);
    #3;
    chk("pre_rst_busy", busy, 1'b1);
    reset = 0;
    #1;
    chk("arst_vo", valid_out, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_err", rate_err, 1'b0);
    chk("arst_do", data_out, 1'b0);
    @(negedge clk);
    reset = 1;
    repeat (4) @(negedge clk);
    chk("hold_idle", busy, 1'b0);
    valid_in = 0; enable = 0;
    repeat (2) @(negedge clk);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      int ab;
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(40)) : -1;
      run_frame(2'($urandom), int'($urandom_range(24)),
                {$urandom, $urandom}, 64, int'($urandom_range(50)), ab, 60);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wifi_tx_puncture_ctrl.md
Name: wifi_tx_puncture_ctrl

Overview:
- Sequences the WIFI TX puncturing stage. It sits between the convolutional encoder's serial coded-bit stream and the interleaver.
- Applies the selected code-rate keep/drop pattern and counts transmitted coded bits against a frame length.
- Signals `finished` when the frame's coded bits have all been emitted.
- Replaces the pass-through puncturer with a real rate-controlled sequencer.

Parameters:
- LEN_W, 16, width of the output coded-bit length counter and `num_out` port.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  frame enable: rising into IDLE starts a frame; must stay high for the whole frame
- rate  input  2  code rate: 00=1/2, 01=3/4, 10=2/3, 11=reserved; sampled at start only
- num_out  input  LEN_W  number of coded bits to emit this frame; sampled at start only
- valid_in  input  1  data_in carries a coded bit this cycle
- data_in  input  1  serial coded bit, order A0,B0,A1,B1,...
- valid_out  output  1  data_out carries a kept bit
- data_out  output  1  punctured serial bit
- finished  output  1  one-cycle pulse at end of a completed frame
- busy  output  1  high in RUN
- rate_err  output  1  sticky: reserved rate latched; cleared at next start

Behaviour:
- Reset (reset=0, async): state=IDLE; valid_out, data_out, finished, busy and rate_err = 0; pattern pointer and out_cnt cleared.

States:
- IDLE:
  - If enable=1: latch rate into rate_q and num_out into len_q; clear pointer and out_cnt; set rate_err=(rate==11).
  - If num_out==0: go to DONE. Otherwise go to RUN.
  - valid_in is ignored in IDLE.
- RUN (busy=1):
  - On each valid_in=1: look up keep=mask[ptr]; ptr advances modulo the pattern period. Keep and drop bits both advance ptr.
  - If keep: the next cycle has valid_out=1 and data_out=data_in (1-cycle registered latency), and out_cnt increments.
  - If not keep: valid_out=0 the next cycle.
  - valid_in=0: nothing advances; valid_out=0 the next cycle.
  - When a kept bit makes out_cnt==len_q: go to DONE. Later valid_in in that frame is ignored.
  - If enable=0 in RUN: abort to IDLE. ptr and out_cnt are cleared, no finished pulse, and a kept bit already registered still emits.
- DONE: finished=1 for exactly one cycle, then go to IDLE. A new frame needs enable low for at least one cycle and then high again. enable held high does not restart.

Patterns (ptr 0 first):
- 1/2: period 2, mask 1,1.
- 3/4: period 6, mask 1,1,1,0,0,1. Keeps A0 B0 A1 B2.
- 2/3: period 4, mask 1,1,1,0. Keeps A0 B0 A1.
- Reserved (11): behaves as 1/2 with rate_err=1.

Other rules:
- Counter: out_cnt is LEN_W bits and never wraps; the maximum frame is 2^LEN_W-1 bits.
- Simultaneous events: if enable falls on the same cycle as the final kept bit, abort wins: no finished, state=IDLE. The last bit still emits on valid_out.
- Changing rate or num_out mid-frame has no effect.

Optional Feature:
- WIFI_PUNCT_R23_EN
  - Defined: rate=10 selects 2/3 puncturing as above.
  - Undefined: rate=10 is treated as reserved, i.e. 1/2 pattern with rate_err=1, and the 2/3 mask logic is not built.

Test Plan:
- Rate 3/4, num_out=8, 12 consecutive valid bits 1,0,1,1,0,1,0,1,1,0,1,1 -> valid_out on 8 cycles carrying 1,0,1,1,0,1,1,1. finished pulses 1 cycle after the last valid_out. busy falls with DONE.
- Rate 1/2, num_out=5, 10 input bits with valid_in gaps -> the first 5 bits pass with 1-cycle latency, and gaps are mirrored as valid_out=0. Input bits 6-10 are ignored. finished pulses once.
- Rate 2/3 (macro defined), num_out=6, 8 bits 1,1,1,1,0,0,0,1 -> output 1,1,1,0,0,0. Repeat with the macro undefined -> the 1/2 pattern is used, rate_err=1, and the first 6 bits are output.
- num_out=0, enable rises -> no valid_out, finished pulses on the 2nd cycle after the enable edge, busy never high.
- Rate 3/4 with enable dropped after 5 inputs -> no finished, IDLE. Restarting at rate 1/2 shows ptr reset: the first 2 inputs both emerge.
- Assert reset low mid-RUN, asynchronously between clock edges -> all outputs 0 immediately. After release, IDLE is held until a fresh enable edge.
